// File: rtl/mux_seq_nx1.sv
// Registered N-channel multiplexer with a manual select mode and a round-robin scan mode.
// Optional build macro MUX_SEQ_MASK_EN adds a per-channel enable mask (ch_mask) for scan and manual select.
module mux_seq_nx1 #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] A,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              en,
`ifdef MUX_SEQ_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]      Y,
    output logic [SEL_W-1:0]  ch_out,
    output logic              valid,
    output logic              wrap
);

    localparam int               CH_P    = 2 ** SEL_W;
    localparam logic [SEL_W:0]   N_CH_L  = (SEL_W + 1)'(N_CH);
    localparam logic [7:0]       DW_LAST = 8'(DWELL - 1);

    // Channel table padded to a power of two: indices past N_CH read as a disabled, zero channel.
    logic [W-1:0]    ch [CH_P];
    logic [CH_P-1:0] ch_en;

    for (genvar k = 0; k < CH_P; k++) begin : g_ch
        if (k < N_CH) begin : g_real
            assign ch[k] = A[k*W +: W];
`ifdef MUX_SEQ_MASK_EN
            assign ch_en[k] = ch_mask[k];
`else
            assign ch_en[k] = 1'b1;
`endif
        end else begin : g_pad
            assign ch[k]    = '0;
            assign ch_en[k] = 1'b0;
        end
    end

    logic [SEL_W-1:0] ptr;
    logic [7:0]       dcnt;
    logic             mode_q;

    logic             entry;
    logic             any_en;
    logic [SEL_W-1:0] first_ch;
    logic [SEL_W-1:0] cur_ptr;
    logic [7:0]       cur_dcnt;
    logic [SEL_W-1:0] next_ch;

    // The scan-entry cycle is treated as dwell cycle 0 of the first enabled channel.
    always_comb begin
        logic [SEL_W:0] idx_w;
        // NOTE: every always_comb output is defaulted before any branch so no latch can be inferred.
        entry    = mode && !mode_q;
        any_en   = |ch_en;
        first_ch = '0;
        next_ch  = '0;
        idx_w    = '0;
        for (int k = CH_P - 1; k >= 0; k--) begin
            if (ch_en[k]) first_ch = SEL_W'(k);
        end
        cur_ptr  = entry ? first_ch : ptr;
        cur_dcnt = entry ? 8'd0 : dcnt;
        next_ch  = cur_ptr;
        // Descending search so the nearest enabled successor (wrapping) wins.
        for (int i = N_CH; i >= 1; i--) begin
            idx_w = {1'b0, cur_ptr} + (SEL_W + 1)'(i);
            if (idx_w >= N_CH_L) idx_w = idx_w - N_CH_L;
            if (ch_en[idx_w[SEL_W-1:0]]) next_ch = idx_w[SEL_W-1:0];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            dcnt   <= '0;
            mode_q <= 1'b0;
            Y      <= '0;
            ch_out <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            mode_q <= mode;
            wrap   <= 1'b0;
            if (!mode) begin
                Y      <= ch_en[sel] ? ch[sel] : '0;
                ch_out <= sel;
                valid  <= ch_en[sel];
            end else if (!any_en) begin
                Y      <= '0;
                ch_out <= ptr;
                valid  <= 1'b0;
            end else begin
                Y      <= ch[cur_ptr];
                ch_out <= cur_ptr;
                valid  <= 1'b1;
                if (cur_dcnt == DW_LAST) begin
                    dcnt <= 8'd0;
                    ptr  <= next_ch;
                    wrap <= (next_ch <= cur_ptr);
                end else begin
                    dcnt <= cur_dcnt + 8'd1;
                    ptr  <= cur_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_seq_nx1.sv
// Self-checking bench for mux_seq_nx1 (N_CH=12, W=8, DWELL=3): manual table, scan sweeps,
// enable freeze, scan re-entry and asynchronous reset; mask scenarios when MUX_SEQ_MASK_EN is set.
module tb_mux_seq_nx1;

    localparam int N_CH  = 12;
    localparam int W     = 8;
    localparam int DWELL = 3;
    localparam int SEL_W = $clog2(N_CH);

    typedef struct packed {
        logic [W-1:0]     y;
        logic [SEL_W-1:0] ch;
        logic             valid;
        logic             wrap;
    } exp_t;

    typedef struct packed {
        logic             en;
        logic [SEL_W-1:0] sel;
        exp_t             exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH*W-1:0] A;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic              en;
`ifdef MUX_SEQ_MASK_EN
    logic [N_CH-1:0]   ch_mask;
`endif
    logic [W-1:0]      Y;
    logic [SEL_W-1:0]  ch_out;
    logic              valid;
    logic              wrap;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vt[16];

    mux_seq_nx1 #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .sel    (sel),
        .mode   (mode),
        .en     (en),
`ifdef MUX_SEQ_MASK_EN
        .ch_mask(ch_mask),
`endif
        .Y      (Y),
        .ch_out (ch_out),
        .valid  (valid),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] chan_val(input int c);
        return 8'(17 * (c + 1));
    endfunction

    function automatic exp_t mk(input int c, input logic [W-1:0] y, input logic v, input logic w);
        exp_t e;
        e.y = y; e.ch = SEL_W'(c); e.valid = v; e.wrap = w;
        return e;
    endfunction

    // Expected output for dwell cycle t after scan entry with all channels enabled.
    function automatic exp_t scan_exp(input int t);
        int c;
        c = (t / DWELL) % N_CH;
        return mk(c, chan_val(c), 1'b1, (t % (DWELL * N_CH)) == (DWELL * N_CH - 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("Y",      32'(Y),      32'(x.y));
        check("ch_out", 32'(ch_out), 32'(x.ch));
        check("valid",  32'(valid),  32'(x.valid));
        check("wrap",   32'(wrap),   32'(x.wrap));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_Y"},      32'(Y),      32'd0);
        check({tag, "_ch_out"}, 32'(ch_out), 32'd0);
        check({tag, "_valid"},  32'(valid),  32'd0);
        check({tag, "_wrap"},   32'(wrap),   32'd0);
    endtask

    initial begin
        // Manual-mode table: in-range sweep, two out-of-range selects, a frozen cycle, recovery.
        for (int k = 0; k < 14; k++) begin
            vt[k].en  = 1'b1;
            vt[k].sel = SEL_W'(k);
            vt[k].exp = (k < N_CH) ? mk(k, chan_val(k), 1'b1, 1'b0) : mk(k, 8'h00, 1'b0, 1'b0);
        end
        vt[14] = '{en: 1'b0, sel: 4'd2,  exp: mk(13, 8'h00, 1'b0, 1'b0)};
        vt[15] = '{en: 1'b1, sel: 4'd11, exp: mk(11, 8'hCC, 1'b1, 1'b0)};

        for (int k = 0; k < N_CH; k++) A[k*W +: W] = chan_val(k);
        rst_n = 1'b0;
        mode  = 1'b0;
        en    = 1'b0;
        sel   = '0;
`ifdef MUX_SEQ_MASK_EN
        ch_mask = '1;
`endif
        @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            en  = vt[i].en;
            sel = vt[i].sel;
            step(vt[i].exp);
        end

        // Scan sweep with a 5-cycle freeze mid-dwell on channel 2 and a freeze right after wrap.
        en   = 1'b1;
        mode = 1'b1;
        for (int t = 0; t <= 40; t++) begin
            step(scan_exp(t));
            if (t == 7) begin
                en = 1'b0;
                for (int j = 0; j < 5; j++) step(mk(2, 8'h33, 1'b1, 1'b0));
                en = 1'b1;
            end
            if (t == 35) begin
                en = 1'b0;
                step(mk(11, 8'hCC, 1'b1, 1'b0));
                en = 1'b1;
            end
        end

        // Leave scan, take one manual sample, re-enter: sweep restarts at channel 0.
        mode = 1'b0;
        sel  = 4'd4;
        step(mk(4, 8'h55, 1'b1, 1'b0));
        mode = 1'b1;
        for (int t = 0; t <= 16; t++) step(scan_exp(t));

        // Asynchronous reset while channel 5 is mid-dwell, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        rst_n = 1'b1;
        for (int t = 0; t <= 3; t++) step(scan_exp(t));

`ifdef MUX_SEQ_MASK_EN
        begin
            int seq [3];
            seq = '{2, 5, 7};
            mode    = 1'b0;
            ch_mask = 12'b0000_1010_0100;
            sel     = 4'd3;
            step(mk(3, 8'h00, 1'b0, 1'b0));
            sel     = 4'd5;
            step(mk(5, 8'h66, 1'b1, 1'b0));
            mode = 1'b1;
            for (int t = 0; t < 12; t++) begin
                int c;
                c = seq[(t / DWELL) % 3];
                step(mk(c, chan_val(c), 1'b1, (t % 9) == 8));
            end
            ch_mask = '0;
            step(mk(5, 8'h00, 1'b0, 1'b0));
            step(mk(5, 8'h00, 1'b0, 1'b0));
        end
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
